hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: load-use/MDU stalls, branch flush, perf counters
module hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             use_rs_ID,
    input  logic             use_rt_ID,
    input  logic             hilo_rd_ID,
    input  logic [4:0]       RW_EX,
    input  logic             MemRead_EX,
    input  logic             branch_taken_EX,
    input  logic             mdu_start_EX,
    input  logic             perf_clr,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STALL_LU  = 2'd1,
        STALL_MDU = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    localparam logic [7:0] LAT = 8'(MDU_LAT);

    state_t           state_q, state_d;
    logic [7:0]       mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mdu_hz;
    logic stall;

    assign load_use = MemRead_EX && (RW_EX != 5'd0) &&
                      ((use_rs_ID && (RW_EX == rs_ID)) ||
                       (use_rt_ID && (RW_EX == rt_ID)));

    assign mdu_busy = (mdu_cnt_q != 8'd0);

    // Gating with rst_n keeps a reset cycle free of MDU stalls and of a stray done strobe.
    assign mdu_hz   = hilo_rd_ID && mdu_busy && rst_n;
    assign mdu_done = (mdu_cnt_q == 8'd1) && !mdu_start_EX && rst_n;

    assign stall    = !branch_taken_EX && (load_use || mdu_hz);

    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (branch_taken_EX) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (load_use || mdu_hz) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    always_comb begin
        state_d = RUN;
        if (branch_taken_EX) begin
            state_d = FLUSH;
        end else if (mdu_hz) begin
            state_d = STALL_MDU;
        end else if (load_use) begin
            state_d = STALL_LU;
        end
    end

    // A start while busy restarts the full latency.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_start_EX) begin
            mdu_cnt_d = LAT;
        end else if (mdu_cnt_q != 8'd0) begin
            mdu_cnt_d = mdu_cnt_q - 8'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (branch_taken_EX && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            mdu_cnt_q   <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ctrl_state = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_ID, rt_ID, RW_EX;
    logic       use_rs_ID, use_rt_ID, hilo_rd_ID;
    logic       MemRead_EX, branch_taken_EX, mdu_start_EX, perf_clr;
    logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic       mdu_busy, mdu_done;
    logic [1:0] ctrl_state;
    logic [3:0] stall_cnt, flush_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_ctrl #(.MDU_LAT(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_ID(rs_ID), .rt_ID(rt_ID),
        .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
        .hilo_rd_ID(hilo_rd_ID), .RW_EX(RW_EX),
        .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
        .mdu_start_EX(mdu_start_EX), .perf_clr(perf_clr),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rs_ID = 5'd0; rt_ID = 5'd0; RW_EX = 5'd0;
        use_rs_ID = 1'b0; use_rt_ID = 1'b0; hilo_rd_ID = 1'b0;
        MemRead_EX = 1'b0; branch_taken_EX = 1'b0;
        mdu_start_EX = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_load_use();
        MemRead_EX = 1'b1; RW_EX = 5'd8; rs_ID = 5'd8; use_rs_ID = 1'b1;
    endtask

    task automatic edge_wait();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        edge_wait();
        n_cmp++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", ctrl_state); end
        n_cmp++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) begin n_fail++; $display("FAIL reset_mdu got busy=%b done=%b want 0/0", mdu_busy, mdu_done); end
        n_cmp++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnts got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        n_cmp++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1100) begin n_fail++; $display("FAIL reset_run_outs got %b want 1100", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}); end
        @(negedge clk);
        set_load_use();
        #1;
        n_cmp++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b0001) begin n_fail++; $display("FAIL reset_lu_outs got %b want 0001", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        edge_wait();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_load_use();
        #1;
        n_cmp++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b0001) begin n_fail++; $display("FAIL lu_outs got %b want 0001", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}); end
        edge_wait();
        n_cmp++; if (ctrl_state !== 2'd1) begin n_fail++; $display("FAIL lu_state got %0d want 1", ctrl_state); end
        n_cmp++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
        n_cmp++; if (PC_Write !== 1'b0 || ID_EX_Flush !== 1'b1) begin n_fail++; $display("FAIL lu_repeat_outs got pc=%b idex=%b want 0/1", PC_Write, ID_EX_Flush); end
        edge_wait();
        n_cmp++; if (ctrl_state !== 2'd1 || stall_cnt !== 4'd2) begin n_fail++; $display("FAIL lu_repeat got state=%0d cnt=%0d want 1/2", ctrl_state, stall_cnt); end
    endtask

    task automatic test_no_stall();
        @(negedge clk);
        set_load_use(); RW_EX = 5'd0; rs_ID = 5'd0;
        #1;
        n_cmp++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1100) begin n_fail++; $display("FAIL r0_outs got %b want 1100", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}); end
        edge_wait();
        n_cmp++; if (ctrl_state !== 2'd0 || stall_cnt !== 4'd2) begin n_fail++; $display("FAIL r0_regs got state=%0d cnt=%0d want 0/2", ctrl_state, stall_cnt); end
        @(negedge clk);
        set_load_use(); use_rs_ID = 1'b0;
        #1;
        n_cmp++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1100) begin n_fail++; $display("FAIL nouse_outs got %b want 1100", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}); end
        @(negedge clk);
        idle_inputs();
        MemRead_EX = 1'b1; RW_EX = 5'd17; rt_ID = 5'd17; use_rt_ID = 1'b1; rs_ID = 5'd3; use_rs_ID = 1'b1;
        #1;
        n_cmp++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b0001) begin n_fail++; $display("FAIL rt_lu_outs got %b want 0001", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}); end
        edge_wait();
        n_cmp++; if (ctrl_state !== 2'd1 || stall_cnt !== 4'd3) begin n_fail++; $display("FAIL rt_lu_regs got state=%0d cnt=%0d want 1/3", ctrl_state, stall_cnt); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        idle_inputs();
        set_load_use();
        branch_taken_EX = 1'b1;
        #1;
        n_cmp++; if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1111) begin n_fail++; $display("FAIL br_outs got %b want 1111", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}); end
        edge_wait();
        n_cmp++; if (ctrl_state !== 2'd3) begin n_fail++; $display("FAIL br_state got %0d want 3", ctrl_state); end
        n_cmp++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd3) begin n_fail++; $display("FAIL br_cnts got flush=%0d stall=%0d want 1/3", flush_cnt, stall_cnt); end
        @(negedge clk);
        idle_inputs();
        edge_wait();
        n_cmp++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL br_return got %0d want 0", ctrl_state); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        idle_inputs();
        perf_clr = 1'b1;
        edge_wait();
        n_cmp++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_fail++; $display("FAIL clr got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        perf_clr = 1'b0;
        set_load_use();
        repeat (20) edge_wait();
        n_cmp++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL stall_sat got %0h want f", stall_cnt); end
        @(negedge clk);
        perf_clr = 1'b1;
        edge_wait();
        n_cmp++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_prio got %0h want 0", stall_cnt); end
        @(negedge clk);
        idle_inputs();
        branch_taken_EX = 1'b1;
        repeat (20) edge_wait();
        n_cmp++; if (flush_cnt !== 4'hF || stall_cnt !== 4'd0) begin n_fail++; $display("FAIL flush_sat got flush=%0h stall=%0h want f/0", flush_cnt, stall_cnt); end
        @(negedge clk);
        idle_inputs();
        perf_clr = 1'b1;
        edge_wait();
        @(negedge clk);
        perf_clr = 1'b0;
    endtask

    task automatic test_mdu();
        int bad_busy = 0;
        int bad_done = 0;
        int bad_stall = 0;
        @(negedge clk);
        idle_inputs();
        mdu_start_EX = 1'b1;
        hilo_rd_ID = 1'b1;
        #1;
        n_cmp++; if (PC_Write !== 1'b1 || mdu_busy !== 1'b0) begin n_fail++; $display("FAIL mdu_issue got pc=%b busy=%b want 1/0", PC_Write, mdu_busy); end
        edge_wait();
        @(negedge clk);
        mdu_start_EX = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            if (mdu_busy !== 1'b1) bad_busy++;
            if (mdu_done !== (i == 32)) bad_done++;
            if (PC_Write !== 1'b0 || ID_EX_Flush !== 1'b1) bad_stall++;
            edge_wait();
            if (ctrl_state !== 2'd2) bad_stall++;
        end
        n_cmp++; if (bad_busy != 0) begin n_fail++; $display("FAIL mdu_busy_window got %0d bad cycles want 0", bad_busy); end
        n_cmp++; if (bad_done != 0) begin n_fail++; $display("FAIL mdu_done_pulse got %0d bad cycles want 0", bad_done); end
        n_cmp++; if (bad_stall != 0) begin n_fail++; $display("FAIL mdu_stall got %0d bad cycles want 0", bad_stall); end
        @(negedge clk);
        #1;
        n_cmp++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0 || PC_Write !== 1'b1) begin n_fail++; $display("FAIL mdu_release got busy=%b done=%b pc=%b want 0/0/1", mdu_busy, mdu_done, PC_Write); end
        edge_wait();
        n_cmp++; if (ctrl_state !== 2'd0 || stall_cnt !== 4'hF) begin n_fail++; $display("FAIL mdu_after got state=%0d stall=%0h want 0/f", ctrl_state, stall_cnt); end
    endtask

    task automatic test_reset_mid_mdu();
        int dones = 0;
        @(negedge clk);
        idle_inputs();
        mdu_start_EX = 1'b1;
        edge_wait();
        @(negedge clk);
        mdu_start_EX = 1'b0;
        repeat (8) edge_wait();
        @(negedge clk);
        rst_n = 1'b0;
        hilo_rd_ID = 1'b1;
        #1;
        n_cmp++; if (mdu_busy !== 1'b1 || PC_Write !== 1'b1 || mdu_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_comb got busy=%b pc=%b done=%b want 1/1/0", mdu_busy, PC_Write, mdu_done); end
        edge_wait();
        n_cmp++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mdu got busy=%b done=%b want 0/0", mdu_busy, mdu_done); end
        n_cmp++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || ctrl_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_regs got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, ctrl_state); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        repeat (40) begin
            #1;
            if (mdu_done !== 1'b0 || mdu_busy !== 1'b0) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", dones); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_saturate();
        test_mdu();
        test_reset_mid_mdu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
